// File: rtl/sdram_if.sv
// Pin-level bundle between an SDRAM controller (master) and the responder (slave).
// A command is present on a rising clk edge when sdram_cke=1 and sdram_ncs=0; there
// is no backpressure, every command is taken on the edge it is sampled, and read data
// is valid on dq_out exactly in the cycles where dq_oe=1.
interface sdram_if;
   logic        sdram_cke;
   logic        sdram_ncs;
   logic        sdram_nras;
   logic        sdram_ncas;
   logic        sdram_nwe;
   logic [1:0]  sdram_ba;
   logic [10:0] sdram_a;
   logic [3:0]  sdram_dqm;
   logic [31:0] dq_in;
   logic [31:0] dq_out;
   logic        dq_oe;

   modport master (
      output sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
      output sdram_ba, sdram_a, sdram_dqm, dq_in,
      input  dq_out, dq_oe
   );

   modport slave (
      input  sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
      input  sdram_ba, sdram_a, sdram_dqm, dq_in,
      output dq_out, dq_oe
   );
endinterface

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: command decode, init sequencing, per-bank row state,
// byte-masked backing array, CAS-latency read pipeline and sticky error flags.
module sdram_responder #(
   parameter int MEM_AW      = 10,
   parameter int T_RP        = 1,
   parameter int T_RCD       = 1,
   parameter int T_RC        = 4,
   parameter int T_WR        = 2,
   parameter int T_MRD       = 2,
   parameter int REFRESH_MAX = 720
) (
   input  logic        clk,
   input  logic        reset,
   sdram_if.slave      bus,
   output logic        init_done,
   output logic [1:0]  cas_lat,
   output logic [15:0] ref_count,
   output logic [4:0]  err,
   output logic [1:0]  init_state
);

   typedef enum logic [1:0] {
      ST_POWERUP    = 2'd0,
      ST_PRECHARGED = 2'd1,
      ST_REFRESHED  = 2'd2,
      ST_READY      = 2'd3
   } state_t;

   // Timer values hold "edges since the event", so a compare against the minimum
   // distance is direct; all timers saturate so idle time never wraps into an error.
   localparam logic [3:0]  T_RP4     = 4'(T_RP);
   localparam logic [3:0]  T_RDP4    = 4'(T_RP + 1);
   localparam logic [3:0]  T_WRP4    = 4'(T_WR + T_RP);
   localparam logic [3:0]  T_RCD4    = 4'(T_RCD);
   localparam logic [3:0]  T_RC4     = 4'(T_RC);
   localparam logic [3:0]  T_MRD4    = 4'(T_MRD);
   localparam logic [15:0] T_RC16    = 16'(T_RC);
   localparam logic [15:0] REF_MAX16 = 16'(REFRESH_MAX);

   state_t      state, state_nxt;
   logic        pc_ref;
   logic        ready_ok, mrs_early;

   logic        cmd_on;
   logic [2:0]  code;
   logic        is_mrs, is_ref, is_pre, is_act, is_wr, is_rd, is_bad, is_cmd;
   logic [1:0]  ba;
   logic        ap, bank_hit, rd_go, wr_go, mrs_ok;

   logic [3:0]  bank_open;
   logic [10:0] bank_row [4];
   logic [3:0]  act_age  [4];
   logic [3:0]  pre_age  [4];
   logic [3:0]  pre_need [4];
   logic [15:0] ref_age;
   logic [3:0]  mrs_age;

   logic [20:0]       idx_full;
   logic [MEM_AW-1:0] mem_idx;
   logic [31:0]       mem [0:(1<<MEM_AW)-1];
   logic [31:0]       rd_mask;
   logic              p1_v, p2_v, oe_next;
   logic [31:0]       p1_d, p2_d, d_next;
   logic [4:0]        err_set;

   // Command decode; deselect and cke=0 look like NOP.
   assign cmd_on = bus.sdram_cke & ~bus.sdram_ncs;
   assign code   = {bus.sdram_nras, bus.sdram_ncas, bus.sdram_nwe};
   assign is_mrs = cmd_on && (code == 3'b000);
   assign is_ref = cmd_on && (code == 3'b001);
   assign is_pre = cmd_on && (code == 3'b010);
   assign is_act = cmd_on && (code == 3'b011);
   assign is_wr  = cmd_on && (code == 3'b100);
   assign is_rd  = cmd_on && (code == 3'b101);
   assign is_bad = cmd_on && (code == 3'b110);
   assign is_cmd = is_mrs | is_ref | is_pre | is_act | is_wr | is_rd;

   assign ba       = bus.sdram_ba;
   assign ap       = bus.sdram_a[10];
   assign bank_hit = bank_open[ba];
   assign rd_go    = is_rd & bank_hit;
   assign wr_go    = is_wr & bank_hit;
   assign mrs_ok   = bus.sdram_a[5] && (bus.sdram_a[3:0] == 4'd0);

   // Rows and columns alias freely onto the smaller backing array.
   assign idx_full = {ba, bank_row[ba], bus.sdram_a[7:0]};
   assign mem_idx  = MEM_AW'(idx_full);
   assign rd_mask  = {{8{~bus.sdram_dqm[3]}}, {8{~bus.sdram_dqm[2]}},
                      {8{~bus.sdram_dqm[1]}}, {8{~bus.sdram_dqm[0]}}};
   assign oe_next  = (cas_lat == 2'd2) ? p1_v : p2_v;
   assign d_next   = (cas_lat == 2'd2) ? p1_d : p2_d;

   // Init FSM state register, plus the "first refresh seen" flag for PRECHARGED.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_POWERUP;
         pc_ref <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_PRECHARGED && is_ref) pc_ref <= 1'b1;
      end
   end

   // Init FSM next state: MRS always jumps to READY.
   always_comb begin
      state_nxt = state;
      if (is_mrs) begin
         state_nxt = ST_READY;
      end else begin
         case (state)
            ST_POWERUP:    if (is_pre && ap) state_nxt = ST_PRECHARGED;
            ST_PRECHARGED: if (is_ref && pc_ref) state_nxt = ST_REFRESHED;
            default:       state_nxt = state;
         endcase
      end
   end

   // Init FSM outputs.
   always_comb begin
      init_done  = (state == ST_READY);
      ready_ok   = (state == ST_READY);
      mrs_early  = (state == ST_POWERUP) || (state == ST_PRECHARGED);
      init_state = state;
   end

   // Error detection for the command on this edge.
   always_comb begin
      err_set = '0;
      if (is_bad) err_set[0] = 1'b1;
      if (!ready_ok && (is_act || is_rd || is_wr)) err_set[0] = 1'b1;
      if (is_mrs && (mrs_early || !mrs_ok)) err_set[0] = 1'b1;
      if (is_cmd && ((ref_age < T_RC16) || (mrs_age < T_MRD4))) err_set[1] = 1'b1;
      if (is_act && ((pre_age[ba] < pre_need[ba]) || (act_age[ba] < T_RC4))) err_set[1] = 1'b1;
      if ((rd_go || wr_go) && (act_age[ba] < T_RCD4)) err_set[1] = 1'b1;
      if (is_act && bank_hit) err_set[2] = 1'b1;
      if ((is_rd || is_wr) && !bank_hit) err_set[2] = 1'b1;
      if (is_ref && (bank_open != 4'd0)) err_set[2] = 1'b1;
      if (init_done && (ref_age > REF_MAX16)) err_set[3] = 1'b1;
      if (is_wr && (bus.dq_oe || oe_next)) err_set[4] = 1'b1;
   end

   // Per-bank open/row state and activate/precharge timers.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_open <= '0;
         for (int b = 0; b < 4; b++) begin
            bank_row[b] <= '0;
            act_age[b]  <= 4'hF;
            pre_age[b]  <= 4'hF;
            pre_need[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (act_age[b] != 4'hF) act_age[b] <= act_age[b] + 4'd1;
            if (pre_age[b] != 4'hF) pre_age[b] <= pre_age[b] + 4'd1;
            if (is_pre && (ap || ba == 2'(b))) begin
               bank_open[b] <= 1'b0;
               pre_age[b]   <= 4'd1;
               pre_need[b]  <= T_RP4;
            end
         end
         if (is_act) begin
            bank_open[ba] <= 1'b1;
            bank_row[ba]  <= bus.sdram_a;
            act_age[ba]   <= 4'd1;
         end
         if ((rd_go || wr_go) && ap) begin
            bank_open[ba] <= 1'b0;
            pre_age[ba]   <= 4'd1;
            pre_need[ba]  <= rd_go ? T_RDP4 : T_WRP4;
         end
      end
   end

   // Global timers, mode register, refresh counter and sticky errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_age   <= 16'hFFFF;
         mrs_age   <= 4'hF;
         cas_lat   <= 2'd2;
         ref_count <= '0;
         err       <= '0;
      end else begin
         if (is_ref) ref_age <= 16'd1;
         else if (ref_age != 16'hFFFF) ref_age <= ref_age + 16'd1;
         if (is_mrs) mrs_age <= 4'd1;
         else if (mrs_age != 4'hF) mrs_age <= mrs_age + 4'd1;
         if (is_mrs && mrs_ok) cas_lat <= bus.sdram_a[5:4];
         if (is_ref && ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
         err <= err | err_set;
      end
   end

   // Backing array write with per-byte masks; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_go) begin
         for (int l = 0; l < 4; l++) begin
            if (!bus.sdram_dqm[l]) mem[mem_idx][8*l +: 8] <= bus.dq_in[8*l +: 8];
         end
      end
   end

   // Read pipeline: stage 1 at the READ edge, stage 2 one later, output picks by CAS.
   always_ff @(posedge clk) begin
      if (reset) begin
         p1_v       <= 1'b0;
         p2_v       <= 1'b0;
         p1_d       <= '0;
         p2_d       <= '0;
         bus.dq_oe  <= 1'b0;
         bus.dq_out <= '0;
      end else begin
         p1_v       <= rd_go;
         p1_d       <= rd_go ? (mem[mem_idx] & rd_mask) : 32'd0;
         p2_v       <= p1_v;
         p2_d       <= p1_d;
         bus.dq_oe  <= oe_next;
         bus.dq_out <= oe_next ? d_next : 32'd0;
      end
   end

endmodule
